// File: rtl/z_core_icache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
// z_core_icache_refill_ctrl_if : fetch, cache and memory bundle for the refill controller
// Revision 1.0
// ============================================================================
interface z_core_icache_refill_ctrl_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  fetch_req;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic                  fetch_kill;
   logic                  fetch_valid;
   logic [DATA_WIDTH-1:0] fetch_data;
   logic                  fetch_err;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] cache_addr;
   logic                  cache_wen;
   logic [DATA_WIDTH-1:0] cache_wdata;
   logic [DATA_WIDTH-1:0] cache_rdata;
   logic                  cache_hit;
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic                  mem_resp_valid;
   logic [DATA_WIDTH-1:0] mem_resp_data;
   logic                  mem_resp_err;
   logic [31:0]           hit_cnt;
   logic [31:0]           miss_cnt;

   // master = refill controller, slave = fetch unit / cache / memory side
   modport master (
      input  fetch_req, fetch_addr, fetch_kill, cache_rdata, cache_hit,
             mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
      output fetch_valid, fetch_data, fetch_err, busy, cache_addr, cache_wen,
             cache_wdata, mem_req_valid, mem_req_addr, hit_cnt, miss_cnt
   );
   modport slave (
      output fetch_req, fetch_addr, fetch_kill, cache_rdata, cache_hit,
             mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
      input  fetch_valid, fetch_data, fetch_err, busy, cache_addr, cache_wen,
             cache_wdata, mem_req_valid, mem_req_addr, hit_cnt, miss_cnt
   );
endinterface
`default_nettype wire

// File: rtl/z_core_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// z_core_icache_refill_ctrl : single-word instruction cache refill controller
// Revision 1.0
// ============================================================================
module z_core_icache_refill_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   z_core_icache_refill_ctrl_if.master  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      FILL = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nx;
   logic [ADDR_WIDTH-1:0] r_miss_addr;
   logic [DATA_WIDTH-1:0] r_fill_data;
   logic                  r_killed;
   logic                  r_err;
   logic [31:0]           r_hit_cnt;
   logic [31:0]           r_miss_cnt;
   logic                  w_hit_inc;
   logic                  w_miss_inc;
   logic                  w_kill_set;
   logic                  w_err_set;
   logic                  w_data_load;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_miss_addr <= '0;
         r_fill_data <= '0;
         r_killed    <= 1'b0;
         r_err       <= 1'b0;
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_err   <= w_err_set;
         if (w_miss_inc) begin
            r_miss_addr <= bus.fetch_addr;
            r_killed    <= 1'b0;
         end else if (w_kill_set) begin
            r_killed <= 1'b1;
         end
         if (w_data_load) begin
            r_fill_data <= bus.mem_resp_data;
         end
         r_hit_cnt  <= r_hit_cnt + {31'd0, w_hit_inc};
         r_miss_cnt <= r_miss_cnt + {31'd0, w_miss_inc};
      end
   end

   always_comb begin
      w_state_nx        = r_state;
      w_hit_inc         = 1'b0;
      w_miss_inc        = 1'b0;
      w_kill_set        = 1'b0;
      w_err_set         = 1'b0;
      w_data_load       = 1'b0;
      bus.fetch_valid   = 1'b0;
      bus.fetch_data    = r_fill_data;
      bus.cache_addr    = r_miss_addr;
      bus.cache_wen     = 1'b0;
      bus.mem_req_valid = 1'b0;
      case (r_state)
         IDLE: begin
            bus.cache_addr = bus.fetch_addr;
            // rst gates the lookup so no hit can leak out while reset is held
            if (bus.fetch_req && !bus.fetch_kill && !rst) begin
               if (bus.cache_hit) begin
                  bus.fetch_valid = 1'b1;
                  bus.fetch_data  = bus.cache_rdata;
                  w_hit_inc       = 1'b1;
               end else begin
                  w_miss_inc = 1'b1;
                  w_state_nx = REQ;
               end
            end
         end
         REQ: begin
            bus.mem_req_valid = 1'b1;
            w_kill_set        = bus.fetch_kill;
            if (bus.mem_req_ready) begin
               w_state_nx = WAIT;
            end
         end
         WAIT: begin
            w_kill_set = bus.fetch_kill;
            if (bus.mem_resp_valid) begin
               if (bus.mem_resp_err) begin
                  w_err_set  = !(r_killed || bus.fetch_kill);
                  w_state_nx = IDLE;
               end else begin
                  w_data_load = 1'b1;
                  w_state_nx  = FILL;
               end
            end
         end
         FILL: begin
            // the line is written even when the fetch was redirected
            w_kill_set      = bus.fetch_kill;
            bus.cache_wen   = 1'b1;
            bus.fetch_valid = !(r_killed || bus.fetch_kill);
            w_state_nx      = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   assign bus.cache_wdata  = r_fill_data;
   assign bus.mem_req_addr = r_miss_addr;
   assign bus.fetch_err    = r_err;
   assign bus.busy         = (r_state != IDLE);
   assign bus.hit_cnt      = r_hit_cnt;
   assign bus.miss_cnt     = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_z_core_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// tb_z_core_icache_refill_ctrl : randomized bench with a transaction-level cache/memory model
// Revision 1.0
// ============================================================================
module tb_z_core_icache_refill_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   z_core_icache_refill_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   z_core_icache_refill_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Environment cache: one slot per address nibble [15:12], full-address tag
   logic [31:0] cm_tag  [16];
   logic [31:0] cm_data [16];
   logic [15:0] cm_v;
   logic [3:0]  cm_idx;
   logic        cache_clr;
   logic        pre_we;
   logic [31:0] pre_addr;
   logic [31:0] pre_data;

   always_comb begin
      cm_idx          = bus.cache_addr[15:12];
      bus.cache_hit   = cm_v[cm_idx] && (cm_tag[cm_idx] == bus.cache_addr);
      bus.cache_rdata = cm_data[cm_idx];
   end

   always @(posedge clk) begin
      if (cache_clr) begin
         cm_v <= '0;
      end else if (pre_we) begin
         cm_v[pre_addr[15:12]]    <= 1'b1;
         cm_tag[pre_addr[15:12]]  <= pre_addr;
         cm_data[pre_addr[15:12]] <= pre_data;
      end else if (bus.cache_wen) begin
         cm_v[bus.cache_addr[15:12]]    <= 1'b1;
         cm_tag[bus.cache_addr[15:12]]  <= bus.cache_addr;
         cm_data[bus.cache_addr[15:12]] <= bus.cache_wdata;
      end
   end

   // Reference model: which words the cache should hold, and counter totals
   logic [31:0] exp_cache [logic [31:0]];
   logic [31:0] exp_hits;
   logic [31:0] exp_misses;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.fetch_req      = 1'b0;
      bus.fetch_kill     = 1'b0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_err   = 1'b0;
   endtask

   // kill_at: 0 none, 1 in the request cycle, 2 first REQ cycle, 3 first WAIT cycle, 4 FILL cycle
   task automatic fetch(input logic [31:0] a, input int kill_at, input bit err,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
      bit killed;
      bit fv_exp;
      killed = (kill_at == 2) || (kill_at == 3);
      @(negedge clk);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = a;
      bus.fetch_kill = (kill_at == 1);
      #1;
      if (kill_at == 1) begin
         chk("kill_idle_valid", bus.fetch_valid, 0);
         @(posedge clk); #1;
         chk("kill_idle_busy", bus.busy, 0);
         chk("kill_idle_cnt", {bus.hit_cnt, bus.miss_cnt}, {exp_hits, exp_misses});
      end else if (exp_cache.exists(a)) begin
         chk("hit_valid", bus.fetch_valid, 1);
         chk("hit_data", bus.fetch_data, exp_cache[a]);
         chk("hit_no_mreq", bus.mem_req_valid, 0);
         exp_hits++;
         @(posedge clk); #1;
         chk("hit_cnt", bus.hit_cnt, exp_hits);
         chk("hit_busy", bus.busy, 0);
      end else begin
         chk("miss_valid", bus.fetch_valid, 0);
         exp_misses++;
         @(posedge clk); #1;
         chk("miss_cnt", {bus.hit_cnt, bus.miss_cnt}, {exp_hits, exp_misses});
         chk("miss_busy", bus.busy, 1);
         for (int i = 0; i <= rdy_dly; i++) begin
            @(negedge clk);
            bus.fetch_kill     = (kill_at == 2) && (i == 0);
            bus.mem_req_ready  = (i == rdy_dly);
            bus.mem_resp_valid = 1'($urandom_range(0, 1));
            bus.mem_resp_data  = $urandom;
            bus.mem_resp_err   = 1'($urandom_range(0, 1));
            #1;
            chk("req_valid", bus.mem_req_valid, 1);
            chk("req_addr", bus.mem_req_addr, a);
            chk("req_no_fv", bus.fetch_valid, 0);
            chk("req_no_wen", bus.cache_wen, 0);
            @(posedge clk);
         end
         for (int i = 0; i <= rsp_dly; i++) begin
            @(negedge clk);
            bus.fetch_kill     = (kill_at == 3) && (i == 0);
            bus.mem_req_ready  = 1'($urandom_range(0, 1));
            bus.mem_resp_valid = (i == rsp_dly);
            bus.mem_resp_data  = (i == rsp_dly) ? rdata : $urandom;
            bus.mem_resp_err   = (i == rsp_dly) ? err : 1'($urandom_range(0, 1));
            #1;
            chk("wait_no_req", bus.mem_req_valid, 0);
            chk("wait_no_fv", bus.fetch_valid, 0);
            chk("wait_no_wen", bus.cache_wen, 0);
            chk("wait_no_err", bus.fetch_err, 0);
            @(posedge clk);
         end
         @(negedge clk);
         bus.fetch_req      = 1'b0;
         bus.mem_req_ready  = 1'b0;
         bus.mem_resp_valid = 1'b0;
         bus.fetch_kill     = (kill_at == 4);
         #1;
         if (err) begin
            chk("err_pulse", bus.fetch_err, !killed);
            chk("err_no_wen", bus.cache_wen, 0);
            chk("err_idle", bus.busy, 0);
            @(posedge clk); #1;
            chk("err_one_cycle", bus.fetch_err, 0);
         end else begin
            fv_exp = !(killed || (kill_at == 4));
            chk("fill_wen", bus.cache_wen, 1);
            chk("fill_addr", bus.cache_addr, a);
            chk("fill_wdata", bus.cache_wdata, rdata);
            chk("fill_valid", bus.fetch_valid, fv_exp);
            if (fv_exp) chk("fill_data", bus.fetch_data, rdata);
            chk("fill_no_err", bus.fetch_err, 0);
            exp_cache[a] = rdata;
            @(posedge clk); #1;
            chk("fill_done_busy", bus.busy, 0);
            chk("fill_one_wen", bus.cache_wen, 0);
         end
      end
      idle_inputs();
   endtask

   initial begin
      logic [31:0] a;
      int          r;
      int          kill_at;
      checks     = 0;
      failures   = 0;
      exp_hits   = '0;
      exp_misses = '0;
      rst        = 1'b1;
      cache_clr  = 1'b1;
      pre_we     = 1'b0;
      pre_addr   = '0;
      pre_data   = '0;
      bus.fetch_addr    = '0;
      bus.mem_resp_data = '0;
      idle_inputs();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {bus.fetch_valid, bus.fetch_err, bus.busy, bus.cache_wen, bus.mem_req_valid}, 0);
      chk("rst_counters", {bus.hit_cnt, bus.miss_cnt}, 0);
      @(negedge clk);
      rst       = 1'b0;
      cache_clr = 1'b0;
      pre_we    = 1'b1;
      pre_addr  = 32'h0000_1000;
      pre_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      pre_we = 1'b0;
      exp_cache[32'h0000_1000] = 32'hDEAD_BEEF;

      fetch(32'h0000_1000, 0, 1'b0, 0, 0, 32'h0);
      fetch(32'h0000_2000, 0, 1'b0, 2, 3, 32'hCAFE_BABE);
      fetch(32'h0000_2000, 0, 1'b0, 0, 0, 32'h0);
      fetch(32'h0000_3000, 3, 1'b0, 1, 2, 32'h1111_1111);
      fetch(32'h0000_3000, 0, 1'b0, 0, 0, 32'h0);
      fetch(32'h0000_4000, 0, 1'b1, 0, 1, 32'h4444_4444);
      fetch(32'h0000_4000, 0, 1'b0, 1, 0, 32'h4040_4040);

      // Reset while waiting for the response; the late response must be dropped
      @(negedge clk);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_5000;
      @(negedge clk);
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      bus.fetch_req     = 1'b0;
      rst               = 1'b1;
      @(posedge clk); #1;
      chk("rstw_outputs", {bus.fetch_valid, bus.fetch_err, bus.busy, bus.cache_wen, bus.mem_req_valid}, 0);
      chk("rstw_counters", {bus.hit_cnt, bus.miss_cnt}, 0);
      exp_hits   = '0;
      exp_misses = '0;
      @(negedge clk);
      rst                = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h5555_5555;
      #1;
      chk("rstw_stray_wen", bus.cache_wen, 0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("rstw_stray_state", {bus.busy, bus.cache_wen, bus.fetch_valid, bus.fetch_err}, 0);
      end
      idle_inputs();
      fetch(32'h0000_5000, 0, 1'b0, 0, 0, 32'h5A5A_5A5A);

      // Miss counter wraps modulo 2^32
      @(negedge clk);
      force dut.r_miss_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_miss_cnt;
      exp_misses = 32'hFFFF_FFFF;
      fetch(32'h0000_6000, 0, 1'b0, 0, 0, 32'h6666_6666);

      for (int n = 0; n < 80; n++) begin
         a = {16'h0000, 4'($urandom_range(1, 15)), 12'h000};
         r = $urandom_range(0, 9);
         kill_at = (r < 4) ? r + 1 : 0;
         fetch(a, kill_at, ($urandom_range(0, 5) == 0),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end
      @(posedge clk); #1;
      chk("final_counters", {bus.hit_cnt, bus.miss_cnt}, {exp_hits, exp_misses});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/z_core_icache_refill_ctrl.md
Z_CORE_ICACHE_REFILL_CTRL -- requirements
Module: z_core_icache_refill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, fetch/memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fetch_req  input  1  fetch unit requests the word at fetch_addr.
REQ-006 SHALL have port fetch_addr  input  ADDR_WIDTH  fetch address, word aligned.
REQ-007 SHALL have port fetch_kill  input  1  redirect; abandons delivery of the pending fetch.
REQ-008 SHALL have port fetch_valid  output  1  fetch_data valid this cycle.
REQ-009 SHALL have port fetch_data  output  DATA_WIDTH  instruction word.
REQ-010 SHALL have port fetch_err  output  1  one-cycle pulse: refill returned a bus error.
REQ-011 SHALL have port busy  output  1  refill in progress (state != IDLE).
REQ-012 SHALL have port cache_addr  output  ADDR_WIDTH  address to the instruction cache.
REQ-013 SHALL have port cache_wen  output  1  cache write enable.
REQ-014 SHALL have port cache_wdata  output  DATA_WIDTH  cache write data.
REQ-015 SHALL have port cache_rdata  input  DATA_WIDTH  cache combinational read data.
REQ-016 SHALL have port cache_hit  input  1  cache combinational hit for cache_addr.
REQ-017 SHALL have port mem_req_valid  output  1  memory read request valid.
REQ-018 SHALL have port mem_req_ready  input  1  memory accepts the request.
REQ-019 SHALL have port mem_req_addr  output  ADDR_WIDTH  memory read address.
REQ-020 SHALL have port mem_resp_valid  input  1  memory read data valid.
REQ-021 SHALL have port mem_resp_data  input  DATA_WIDTH  memory read data.
REQ-022 SHALL have port mem_resp_err  input  1  bus error, qualified by mem_resp_valid.
REQ-023 SHALL have ports hit_cnt and miss_cnt  output  32 each  performance counters.

Function
REQ-024 SHALL implement an FSM with states IDLE, REQ, WAIT, FILL.
REQ-025 In IDLE, cache_addr SHALL equal fetch_addr; in all other states it SHALL equal the latched miss address (miss_addr).
REQ-026 In IDLE with fetch_req=1, fetch_kill=0, cache_hit=1: fetch_valid=1 and fetch_data=cache_rdata in the same cycle (zero-latency hit); hit_cnt increments by 1.
REQ-027 In IDLE with fetch_req=1, fetch_kill=0, cache_hit=0: latch miss_addr=fetch_addr, clear the killed flag, increment miss_cnt, go to REQ.
REQ-028 In REQ: mem_req_valid=1 and mem_req_addr=miss_addr; both held stable until mem_req_ready=1; on handshake go to WAIT.
REQ-029 In WAIT, mem_resp_valid=1 with mem_resp_err=0: latch mem_resp_data, go to FILL.
REQ-030 In WAIT, mem_resp_valid=1 with mem_resp_err=1: no cache write; fetch_err=1 the next cycle unless killed; go to IDLE.
REQ-031 In FILL, for exactly one cycle: cache_wen=1, cache_wdata=latched data, cache_addr=miss_addr; fetch_valid=1 with fetch_data=latched data unless killed; then go to IDLE.
REQ-032 Miss latency: miss seen in cycle T, mem_req_valid asserted in T+1, fetch_valid in the cycle after the response (FILL).
REQ-033 fetch_kill asserted in REQ, WAIT or FILL SHALL set the killed flag; the refill still completes and writes the cache, but fetch_valid and fetch_err stay 0.
REQ-034 fetch_kill in IDLE SHALL suppress fetch_valid and any miss start that cycle.
REQ-035 mem_resp_valid outside WAIT SHALL be ignored; mem_req_ready outside REQ SHALL be ignored.
REQ-036 The fetch unit SHALL hold fetch_addr stable while fetch_req=1 and busy=1; the controller does not re-sample it.
REQ-037 Counters SHALL wrap modulo 2^32; hit and miss never both increment in one cycle.
REQ-038 Outputs fetch_valid, cache_wen, mem_req_valid, fetch_err SHALL be 0 whenever not explicitly asserted above.

Reset
REQ-039 rst=1 at posedge clk SHALL force IDLE, clear miss_addr, the data latch, the killed flag, hit_cnt and miss_cnt to 0.
REQ-040 While in or after reset: fetch_valid=0, fetch_err=0, busy=0, cache_wen=0, mem_req_valid=0.
REQ-041 Reset mid-refill SHALL abandon the refill with no cache write; a late mem_resp_valid SHALL be ignored.

Verification
REQ-042 Hit: cache preloaded 0x1000=0xDEADBEEF, fetch_req at 0x1000 -> same-cycle fetch_valid, data 0xDEADBEEF, hit_cnt=1, mem_req_valid never high.
REQ-043 Miss: fetch 0x2000, mem_req_ready after 2 cycles, response 0xCAFEBABE 3 cycles later -> mem_req_addr=0x2000 held stable, one cache_wen pulse at 0x2000, fetch_valid with 0xCAFEBABE in FILL, miss_cnt=1; a refetch of 0x2000 then hits.
REQ-044 Kill: miss on 0x3000, fetch_kill in WAIT, response 0x11111111 -> cache written, no fetch_valid; a subsequent fetch of 0x3000 hits with 0x11111111.
REQ-045 Error: miss on 0x4000, response with mem_resp_err=1 -> fetch_err one-cycle pulse, no cache_wen, back in IDLE; the next fetch of 0x4000 misses again.
REQ-046 Reset in WAIT: miss on 0x5000, rst during WAIT, then mem_resp_valid -> all outputs 0, counters 0, no cache_wen, and the stray response is ignored.
REQ-047 Counter wrap: force miss_cnt=0xFFFFFFFF, then one miss -> miss_cnt=0.
